// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared widths, SRAM strobe polarities and arbiter FSM states
// for the APB / host SRAM arbiter and its round-robin helper.
package apb_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // The SRAM macro uses active-low chip and write enables
    localparam logic CE_ON  = 1'b0;
    localparam logic CE_OFF = 1'b1;
    localparam logic WE_ON  = 1'b0;
    localparam logic WE_OFF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_APB_ISSUE  = 2'd1,
        ST_APB_RESP   = 2'd2,
        ST_HOST_ISSUE = 2'd3
    } arbState_t;

    // Map a "this access is a write" flag onto the SRAM WEn level
    function automatic logic weLevel(input logic isWrite);
        return isWrite ? WE_ON : WE_OFF;
    endfunction

endpackage

// File: rtl/apb_sram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter between the APB port and the host port.
// The pointer names the requester that wins the next tie and only moves when
// both sides actually contended, so a lone requester never disturbs fairness.
module rr_arb2 #(
    parameter bit APB_FIRST = 1'b1
) (
    input  logic clock,
    input  logic resetN,
    input  logic i_evaluate,
    input  logic i_reqApb,
    input  logic i_reqHost,
    output logic o_gntApb,
    output logic o_gntHost
);

    logic r_ptrApb;

    // Grant the single requester, or on a tie the one the pointer favours
    always_comb begin
        o_gntApb  = i_evaluate & i_reqApb  & (~i_reqHost | r_ptrApb);
        o_gntHost = i_evaluate & i_reqHost & (~i_reqApb  | ~r_ptrApb);
    end

    // After a tie the pointer moves to the loser so the next tie goes the other way
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_ptrApb <= APB_FIRST;
        end else if (i_evaluate && i_reqApb && i_reqHost) begin
            r_ptrApb <= o_gntHost;
        end
    end

endmodule

// File: rtl/apb_sram_arbiter.sv
// apb_sram_arbiter: shares one single-port synchronous SRAM between an APB
// slave port and a req/gnt host port. SRAM strobes are registered, so an APB
// access takes one wait state; out-of-range APB addresses answer with PSLERR
// without touching the SRAM. The host may be granted on consecutive cycles.
module apb_sram_arbiter
    import apb_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit APB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              PSel,
    input  logic              PEnable,
    input  logic              PWrite,
    input  logic [ADDR_W:0]   PAddress,
    input  logic [DATA_W-1:0] PWData,
    output logic [DATA_W-1:0] PRData,
    output logic              PReady,
    output logic              PSLERR,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              WEn,
    output logic              CEn,
    input  logic [DATA_W-1:0] Q
);

    arbState_t         r_state;
    arbState_t         w_nextState;
    logic              w_decide;
    logic              w_apbReq;
    logic              w_apbOor;
    logic              w_gntApb;
    logic              w_gntHost;
    logic              r_apbPend;
    logic              r_apbErr;
    logic              r_hostRd;
    logic              r_rvalid;
    logic              r_cen;
    logic              r_wen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // Arbitration only happens when the SRAM is free for a new access: from
    // IDLE, or right after a host strobe so the host can stream back-to-back.
    // A setup phase that loses arbitration stays pending through the access
    // phase; dropping PSel discards it.
    assign w_decide = (r_state == ST_IDLE) || (r_state == ST_HOST_ISSUE);
    assign w_apbReq = PSel & (~PEnable | r_apbPend);
    assign w_apbOor = PAddress[ADDR_W];

    rr_arb2 #(
        .APB_FIRST (APB_FIRST)
    ) u_rrArb (
        .clock      (clock),
        .resetN     (resetN),
        .i_evaluate (w_decide),
        .i_reqApb   (w_apbReq),
        .i_reqHost  (host_req),
        .o_gntApb   (w_gntApb),
        .o_gntHost  (w_gntHost)
    );

    // Remember an APB setup that lost to the host until it is served or abandoned
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_apbPend <= 1'b0;
        end else if (!PSel || w_gntApb) begin
            r_apbPend <= 1'b0;
        end else if (w_decide && w_apbReq) begin
            r_apbPend <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next state: out-of-range APB requests skip the SRAM and answer at once
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_HOST_ISSUE: begin
                if (w_gntApb) begin
                    w_nextState = w_apbOor ? ST_APB_RESP : ST_APB_ISSUE;
                end else if (w_gntHost) begin
                    w_nextState = ST_HOST_ISSUE;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_APB_ISSUE: w_nextState = ST_APB_RESP;
            ST_APB_RESP:  w_nextState = ST_IDLE;
            default:      w_nextState = ST_IDLE;
        endcase
    end

    // FSM outputs: APB response in APB_RESP, host grant pulse in HOST_ISSUE
    always_comb begin
        PReady   = (r_state == ST_APB_RESP);
        PSLERR   = (r_state == ST_APB_RESP) && r_apbErr;
        PRData   = ((r_state == ST_APB_RESP) && !r_apbErr) ? Q : '0;
        host_gnt = (r_state == ST_HOST_ISSUE);
    end

    // Registered SRAM strobes, loaded on the edge that grants an access so
    // the strobe lines up with the ISSUE state; CEn drops back otherwise
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_cen    <= CE_OFF;
            r_wen    <= WE_OFF;
            r_addr   <= '0;
            r_data   <= '0;
            r_apbErr <= 1'b0;
            r_hostRd <= 1'b0;
        end else begin
            r_cen <= CE_OFF;
            r_wen <= WE_OFF;
            if (w_gntApb) begin
                r_apbErr <= w_apbOor;
                if (!w_apbOor) begin
                    r_cen  <= CE_ON;
                    r_wen  <= weLevel(PWrite);
                    r_addr <= PAddress[ADDR_W-1:0];
                    r_data <= PWData;
                end
            end else if (w_gntHost) begin
                r_cen    <= CE_ON;
                r_wen    <= weLevel(host_we);
                r_addr   <= host_addr;
                r_data   <= host_wdata;
                r_hostRd <= ~host_we;
            end
        end
    end

    // Host read data arrives the cycle after the read strobe, whatever the FSM does next
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= (r_state == ST_HOST_ISSUE) && r_hostRd;
        end
    end

    assign CEn         = r_cen;
    assign WEn         = r_wen;
    assign A           = r_addr;
    assign D           = r_data;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = Q;

endmodule
